// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_SAT_DIGIT = 4'h9;

    function automatic logic [BCD_DIGIT_W-1:0] add3_adj(input logic [BCD_DIGIT_W-1:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // True when an input of 'width' bits can reach 10^digits.
    function automatic logic ovf_possible(input int width, input int digits);
        longint unsigned limit;
        longint unsigned p;
        logic ok;
        ok = 1'b1;
        p = 1;
        if (width >= 63) begin
            limit = '1;
        end else begin
            limit = (64'd1 << width) - 64'd1;
        end
        for (int i = 0; i < digits; i++) begin
            if (ok) begin
                p = p * 10;
                if (p > limit) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble cell: adds 3 (mod 16) to a BCD digit that is 5 or more.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adj
);

    assign adj = add3_adj(digit);

endmodule

// File: rtl/binary_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, with saturation.
// Define BIN2BCD_BLANK_EN to register a leading-zero blanking mask alongside the result.
module binary_to_bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow,
    output logic [DIGITS-1:0]             blank
);

    localparam int   ACC_W  = BCD_DIGIT_W * DIGITS;
    localparam int   CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic OVF_EN = ovf_possible(WIDTH, DIGITS);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   bin_reg, bin_next;
    logic [ACC_W-1:0]   acc_reg, acc_next;
    logic [ACC_W-1:0]   acc_adj;
    logic               ovf_reg, ovf_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [ACC_W-1:0]   bcd_reg, bcd_next;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .digit (acc_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adj   (acc_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            bin_reg   <= '0;
            acc_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            bcd_reg   <= '0;
        end else begin
            state_reg <= state_next;
            bin_reg   <= bin_next;
            acc_reg   <= acc_next;
            ovf_reg   <= ovf_next;
            cnt_reg   <= cnt_next;
            bcd_reg   <= bcd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bin_next   = bin_reg;
        acc_next   = acc_reg;
        ovf_next   = ovf_reg;
        cnt_next   = cnt_reg;
        bcd_next   = bcd_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    bin_next   = in_bin;
                    acc_next   = '0;
                    ovf_next   = 1'b0;
                    cnt_next   = CNT_W'(WIDTH - 1);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                acc_next = {acc_adj[ACC_W-2:0], bin_reg[WIDTH-1]};
                bin_next = bin_reg << 1;
                // The top digit's MSB leaving the accumulator means the value reached 10^DIGITS.
                ovf_next = ovf_reg | (OVF_EN & acc_adj[ACC_W-1]);
                if (cnt_reg == '0) begin
                    state_next = DONE;
                    bcd_next   = ovf_next ? {DIGITS{BCD_SAT_DIGIT}} : acc_next;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign bcd       = bcd_reg;
    assign overflow  = ovf_reg;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_reg, blank_next;
    logic              lead;

    // Mask is captured on the final shift so it stays aligned with bcd_reg.
    always_comb begin
        blank_next = blank_reg;
        lead       = 1'b0;
        if (state_reg == SHIFT && cnt_reg == '0) begin
            blank_next = '0;
            lead       = ~ovf_next;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                lead          = lead & (acc_next[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
                blank_next[k] = lead;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) blank_reg <= '0;
        else       blank_reg <= blank_next;
    end

    assign blank = blank_reg;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench: directed cases plus a randomized sweep against a decimal reference model.
`timescale 1ns/1ps
module tb_binary_to_bcd_seq;

    logic        clk;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, overflow;
    logic [11:0] in_bin;
    logic [15:0] bcd;
    logic [3:0]  blank;
    logic        in_valid3, in_ready3, out_valid3, out_ready3, overflow3;
    logic [11:0] in_bin3;
    logic [11:0] bcd3;
    logic [2:0]  blank3;

    int n_checks = 0;
    int n_pass   = 0;

    binary_to_bcd_seq #(.WIDTH(12), .DIGITS(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .overflow(overflow), .blank(blank)
    );

    binary_to_bcd_seq #(.WIDTH(12), .DIGITS(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .in_bin(in_bin3),
        .out_valid(out_valid3), .out_ready(out_ready3), .bcd(bcd3), .overflow(overflow3), .blank(blank3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] ref_bcd(input int v, input int dg);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < dg; i++) begin
            r[4*i +: 4] = (v >= pow10(dg)) ? 4'h9 : 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_blank(input int v, input int dg);
        logic [31:0] r = '0;
`ifdef BIN2BCD_BLANK_EN
        if (v < pow10(dg))
            for (int k = 1; k < dg; k++) r[k] = (v < pow10(k));
`endif
        return r;
    endfunction

    function automatic logic [31:0] cur_bcd(input bit d3);
        return d3 ? 32'(bcd3) : 32'(bcd);
    endfunction

    task automatic send(input bit d3, input int v);
        int n = 0;
        while (!(d3 ? in_ready3 : in_ready) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_wait", 32'(n < 50), 32'd1);
        if (d3) begin in_bin3 = 12'(v); in_valid3 = 1'b1; end
        else    begin in_bin  = 12'(v); in_valid  = 1'b1; end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
    endtask

    task automatic wait_done(input bit d3, input int v);
        int lat = 0;
        int dg  = d3 ? 3 : 4;
        logic ov;
        logic [31:0] bl;
        while (!(d3 ? out_valid3 : out_valid) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        ov = d3 ? overflow3 : overflow;
        bl = d3 ? 32'(blank3) : 32'(blank);
        check("latency", 32'(lat), 32'd12);
        check("bcd", cur_bcd(d3), ref_bcd(v, dg));
        check("overflow", 32'(ov), 32'(v >= pow10(dg)));
        check("blank", bl, ref_blank(v, dg));
        $display("txn dut%0d in=%0d bcd=%0h ovf=%0b blank=%0b lat=%0d", dg, v, cur_bcd(d3), ov, bl, lat);
    endtask

    task automatic hold(input bit d3, input int v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(d3 ? out_valid3 : out_valid), 32'd1);
            check("hold_bcd", cur_bcd(d3), ref_bcd(v, d3 ? 3 : 4));
        end
    endtask

    task automatic release_out(input bit d3);
        if (d3) out_ready3 = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready  = 1'b0;
        out_ready3 = 1'b0;
        check("release_valid", 32'(d3 ? out_valid3 : out_valid), 32'd0);
        check("release_ready", 32'(d3 ? in_ready3 : in_ready), 32'd1);
    endtask

    initial begin
        int v;
        reset = 1'b1;
        in_valid = 1'b0; in_bin = '0; out_ready = 1'b0;
        in_valid3 = 1'b0; in_bin3 = '0; out_ready3 = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_blank", 32'(blank), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        send(0, 4095); wait_done(0, 4095); release_out(0);
        send(0, 0);    wait_done(0, 0);    release_out(0);

        send(1, 1000); wait_done(1, 1000); release_out(1);
        send(1, 999);  wait_done(1, 999);  release_out(1);

        // Backpressure: result must stay put and a stray in_valid must be ignored.
        send(0, 42); wait_done(0, 42);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i == 5);
            in_bin   = 12'd7;
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_bcd", 32'(bcd), 32'h0042);
        end
        release_out(0);
        send(0, 7); wait_done(0, 7); release_out(0);

        // Asynchronous reset in the middle of a conversion.
        send(0, 1234);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        send(0, 1234); wait_done(0, 1234); release_out(0);

        for (int i = 0; i < 40; i++) begin
            v = int'($urandom_range(0, 4095));
            send(0, v); wait_done(0, v);
            hold(0, v, int'($urandom_range(0, 3)));
            release_out(0);
        end
        for (int i = 0; i < 10; i++) begin
            v = int'($urandom_range(900, 4095));
            send(1, v); wait_done(1, v);
            hold(1, v, int'($urandom_range(0, 2)));
            release_out(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/binary_to_bcd_seq.md
# binary_to_bcd_seq

Sequential, parametrised binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock, with valid/ready handshakes on both sides. It replaces the wide combinational converter where WIDTH/DIGITS grow too large for single-cycle timing, such as sample counters and frequency readouts feeding the HEX display drivers. It adds overflow saturation and, optionally, leading-zero blanking information for the display path.

## Interface
- WIDTH, 12: binary input width, ≥1.
- DIGITS, 4: number of BCD digits produced, ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; forces the reset state immediately.
- in_valid  in  1  in_bin holds a value to convert.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_bin  in  WIDTH  unsigned binary value.
- out_valid  out  1  bcd/overflow/blank hold a finished result.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  result; ones at [3:0], digit k at [4k+3:4k].
- overflow  out  1  in_bin ≥ 10^DIGITS; bcd saturated.
- blank  out  DIGITS  leading-zero mask, bit k = digit k blanked.

## Operation
- States: IDLE, SHIFT, DONE; held in the shared state enum.
- IDLE: in_ready=1. On in_valid: load in_bin into the binary shift register, clear the BCD accumulator and overflow, set bit counter to WIDTH-1, go to SHIFT.
- SHIFT, per cycle: every digit ≥5 gets +3 (all digits in parallel, from the pre-shift value); then shift {accumulator, binary} left by 1. If the bit shifted out of the top digit's MSB is 1, set a sticky overflow flag. When counter==0, go to DONE; otherwise decrement the counter.
- DONE: out_valid=1; bcd/overflow/blank are stable and do not change until the handshake. If overflow is set, bcd reads all 9s (4'h9 per digit). On out_ready, go to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Arithmetic: the accumulator is exactly 4*DIGITS bits. The +3 is done modulo 16 per digit and cannot carry into the neighbouring digit.
- Overflow is not detectable by the shift rule when 10^DIGITS > 2^WIDTH-1; overflow is then constant 0.
- Digits are never outside 0–9 at out_valid.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, bcd=0, overflow=0, blank=0, counter=0.
- Acceptance edge E0. The shift edges are E1..E_WIDTH. out_valid is high in the cycle after E_WIDTH, so latency = WIDTH cycles from acceptance.
- Minimum initiation interval with out_ready tied high: WIDTH+2 cycles (accept, WIDTH shifts, DONE).
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset mid-SHIFT or during DONE: the conversion is abandoned, outputs take reset values immediately, and no partial result is ever presented.
- Back-to-back: a new in_valid may be accepted on the first IDLE cycle after the DONE handshake.

## Configuration
- BIN2BCD_BLANK_EN defined: blank is computed in DONE.
  - blank[k]=1 if digit k and all higher digits are 0, for k ≥ 1.
  - blank[0] is always 0.
  - On overflow, blank=0.
  - blank is registered alongside bcd.
- BIN2BCD_BLANK_EN undefined: the blank port still exists, is tied to 0, and uses no blanking logic.

## Structure
- Package bin2bcd_pkg holds:
  - the state enum (IDLE, SHIFT, DONE),
  - localparam BCD_DIGIT_W = 4,
  - constant 4'h9 (saturation digit),
  - function add3_adj(digit) returning digit ≥5 ? digit+3 : digit.
- Sub-module bcd_digit_adj: one combinational per-digit add-3 cell, instantiated DIGITS times in a generate loop.
- Counter width is $clog2(WIDTH) (minimum 1).

## Test plan
- WIDTH=12, DIGITS=4, in_bin=4095, out_ready=1 → out_valid exactly 12 cycles after acceptance; bcd=16'h4095, overflow=0.
- in_bin=0 → bcd=16'h0000; with BIN2BCD_BLANK_EN, blank=4'b1110; without it, blank=4'b0000.
- WIDTH=12, DIGITS=3, in_bin=1000 → overflow=1, bcd=12'h999, blank=0. Then in_bin=999 → overflow=0, bcd=12'h999.
- Backpressure: in_bin=42, out_ready=0 for 20 cycles → out_valid stays high, bcd=16'h0042 stable, in_ready=0, and an in_valid pulse of 7 is not accepted. Release out_ready → IDLE next cycle; then 7 converts to 16'h0007.
- Reset asserted 5 cycles into a conversion of 1234 → out_valid=0, bcd=0, in_ready=1 immediately. After release, a new 1234 → 16'h1234 after 12 cycles.
- Randomised sweep over 0..4095 with random out_ready → every result equals the decimal digits of the input, and no result is dropped or duplicated.
